// File: rtl/mib_slave_cmd_bridge.sv
// MIB slave endpoint: decodes the two address phases (and two write-data
// phases) of a MIB transaction, claims it when the address nibble [23:20]
// matches P_MIB_MSN, replays it as one local cmd-bus request and returns the
// MIB ack (plus two read-data words for reads). All outputs are registered.
module mib_slave_cmd_bridge #(
  parameter logic [3:0]  P_MIB_MSN              = 4'h0,
  parameter int unsigned P_CMD_ACK_TIMEOUT_CLKS = 16
) (
  input  logic        i_sysclk,
  input  logic        i_rst_n,
  input  logic        i_mib_start,
  input  logic        i_mib_rd_wr_n,
  input  logic [15:0] i_mib_ad,
  output logic [15:0] o_mib_ad,
  output logic        o_mib_ad_high_z,
  output logic        o_mib_slave_ack,
  output logic        o_cmd_sel,
  output logic        o_cmd_rd_wr_n,
  output logic [19:0] o_cmd_byte_addr,
  output logic [31:0] o_cmd_wdata,
  input  logic [31:0] i_cmd_rdata,
  input  logic        i_cmd_ack,
  output logic        o_cmd_timeout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR2    = 3'd1;
  localparam logic [2:0] S_WDATA1   = 3'd2;
  localparam logic [2:0] S_WDATA2   = 3'd3;
  localparam logic [2:0] S_CMD_WAIT = 3'd4;
  localparam logic [2:0] S_WR_ACK   = 3'd5;
  localparam logic [2:0] S_RD_HI    = 3'd6;
  localparam logic [2:0] S_RD_LO    = 3'd7;

  // Last counter value at which a local ack is still honoured.
  localparam logic [7:0] WAIT_LAST = 8'(P_CMD_ACK_TIMEOUT_CLKS - 1);

  logic [2:0]  state;
  logic [7:0]  addr_hi;
  logic [15:0] addr_lo;
  logic        rd_wr_n;
  logic [15:0] wdata_hi;
  logic [15:0] rdata_lo;
  logic [7:0]  wait_cnt;
  logic        restart;

  // A new start restarts decoding everywhere except while read data is on the bus.
  assign restart = i_mib_start && (state != S_RD_HI) && (state != S_RD_LO);

  // Transaction state machine with registered MIB and cmd-bus outputs.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      addr_hi         <= '0;
      addr_lo         <= '0;
      rd_wr_n         <= 1'b0;
      wdata_hi        <= '0;
      rdata_lo        <= '0;
      wait_cnt        <= '0;
      o_mib_ad        <= '0;
      o_mib_ad_high_z <= 1'b1;
      o_mib_slave_ack <= 1'b0;
      o_cmd_sel       <= 1'b0;
      o_cmd_rd_wr_n   <= 1'b0;
      o_cmd_byte_addr <= '0;
      o_cmd_wdata     <= '0;
      o_cmd_timeout   <= 1'b0;
    end else begin
      o_cmd_sel     <= 1'b0;
      o_cmd_timeout <= 1'b0;
      if (restart) begin
        rd_wr_n         <= i_mib_rd_wr_n;
        addr_hi         <= i_mib_ad[7:0];
        o_mib_slave_ack <= 1'b0;
        o_mib_ad        <= '0;
        o_mib_ad_high_z <= 1'b1;
        o_cmd_rd_wr_n   <= 1'b0;
        o_cmd_byte_addr <= '0;
        o_cmd_wdata     <= '0;
        state           <= S_ADDR2;
      end else begin
        case (state)
          S_IDLE: begin
            o_cmd_rd_wr_n   <= 1'b0;
            o_cmd_byte_addr <= '0;
            o_cmd_wdata     <= '0;
          end
          S_ADDR2: begin
            if (addr_hi[7:4] != P_MIB_MSN) begin
              state <= S_IDLE;
            end else if (rd_wr_n) begin
              o_cmd_sel       <= 1'b1;
              o_cmd_rd_wr_n   <= 1'b1;
              o_cmd_byte_addr <= {addr_hi[3:0], i_mib_ad};
              o_cmd_wdata     <= '0;
              wait_cnt        <= '0;
              state           <= S_CMD_WAIT;
            end else begin
              addr_lo <= i_mib_ad;
              state   <= S_WDATA1;
            end
          end
          S_WDATA1: begin
            wdata_hi <= i_mib_ad;
            state    <= S_WDATA2;
          end
          S_WDATA2: begin
            o_cmd_sel       <= 1'b1;
            o_cmd_rd_wr_n   <= 1'b0;
            o_cmd_byte_addr <= {addr_hi[3:0], addr_lo};
            o_cmd_wdata     <= {wdata_hi, i_mib_ad};
            wait_cnt        <= '0;
            state           <= S_CMD_WAIT;
          end
          S_CMD_WAIT: begin
            if (o_cmd_sel) begin
              wait_cnt <= '0;
            end else if (i_cmd_ack) begin
              o_mib_slave_ack <= 1'b1;
              if (rd_wr_n) begin
                o_mib_ad        <= i_cmd_rdata[31:16];
                rdata_lo        <= i_cmd_rdata[15:0];
                o_mib_ad_high_z <= 1'b0;
                state           <= S_RD_HI;
              end else begin
                state <= S_WR_ACK;
              end
            end else if (wait_cnt == WAIT_LAST) begin
              o_cmd_timeout <= 1'b1;
              state         <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          S_WR_ACK: begin
            o_mib_slave_ack <= 1'b0;
            state           <= S_IDLE;
          end
          S_RD_HI: begin
            o_mib_ad <= rdata_lo;
            state    <= S_RD_LO;
          end
          S_RD_LO: begin
            o_mib_ad        <= '0;
            o_mib_ad_high_z <= 1'b1;
            o_mib_slave_ack <= 1'b0;
            state           <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mib_slave_cmd_bridge.sv
// Self-checking bench for mib_slave_cmd_bridge: a table of single
// transactions plus hand-written abort, reset, protocol-error and
// back-to-back sequences.
module tb_mib_slave_cmd_bridge;

  logic        clk = 1'b0;
  logic        rstN;
  logic        mibStart;
  logic        mibRdWrN;
  logic [15:0] mibAdIn;
  logic [15:0] mibAdOut;
  logic        mibHighZ;
  logic        mibAck;
  logic        cmdSel;
  logic        cmdRdWrN;
  logic [19:0] cmdAddr;
  logic [31:0] cmdWdata;
  logic [31:0] cmdRdata;
  logic        cmdAck;
  logic        cmdTimeout;

  int checks = 0;
  int errors = 0;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  mib_slave_cmd_bridge #(
    .P_MIB_MSN              (4'h0),
    .P_CMD_ACK_TIMEOUT_CLKS (16)
  ) dut (
    .i_sysclk        (clk),
    .i_rst_n         (rstN),
    .i_mib_start     (mibStart),
    .i_mib_rd_wr_n   (mibRdWrN),
    .i_mib_ad        (mibAdIn),
    .o_mib_ad        (mibAdOut),
    .o_mib_ad_high_z (mibHighZ),
    .o_mib_slave_ack (mibAck),
    .o_cmd_sel       (cmdSel),
    .o_cmd_rd_wr_n   (cmdRdWrN),
    .o_cmd_byte_addr (cmdAddr),
    .o_cmd_wdata     (cmdWdata),
    .i_cmd_rdata     (cmdRdata),
    .i_cmd_ack       (cmdAck),
    .o_cmd_timeout   (cmdTimeout)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic [15:0] ap1;
    logic [15:0] ap2;
    logic [15:0] wdHi;
    logic [15:0] wdLo;
    int          ackDelay;
    logic [31:0] rdata;
    int          expSelCycle;
    logic [19:0] expAddr;
    logic [31:0] expWdata;
    int          expAckCycle;
    int          expAckCount;
    logic [15:0] expAd0;
    logic [15:0] expAd1;
    int          expHzLow;
    int          expToCycle;
  } vec_t;

  vec_t vecs[9];

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive all inputs for the current cycle in one go.
  task automatic driveBus(input logic start, input logic rd, input logic [15:0] ad,
                          input logic ack, input logic [31:0] rdata);
    mibStart = start;
    mibRdWrN = rd;
    mibAdIn  = ad;
    cmdAck   = ack;
    cmdRdata = rdata;
  endtask

  // Run one MIB transaction over a fixed window, record what the DUT does, then compare.
  task automatic applyStimulus(input vec_t v);
    int selCycle, selCount, ackCycle, ackCount, hzLow, toCycle, toCount, adBad;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic        rdwrn;
    logic [15:0] ad0, ad1, adDrv;
    logic        ackDrv;
    selCycle = -1; selCount = 0; ackCycle = -1; ackCount = 0;
    hzLow = 0; toCycle = -1; toCount = 0; adBad = 0;
    addr = '0; wdata = '0; rdwrn = 1'b0; ad0 = '0; ad1 = '0;
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      if (cmdSel) begin
        if (selCycle < 0) begin
          selCycle = t; addr = cmdAddr; wdata = cmdWdata; rdwrn = cmdRdWrN;
        end
        selCount++;
      end
      if (mibAck) begin
        if (ackCount == 0) begin ackCycle = t; ad0 = mibAdOut; end
        else if (ackCount == 1) ad1 = mibAdOut;
        ackCount++;
      end
      if (!mibHighZ) hzLow++;
      if (mibHighZ && mibAdOut != 16'h0) adBad++;
      if (cmdTimeout) begin
        if (toCycle < 0) toCycle = t;
        toCount++;
      end
      case (t)
        0:       adDrv = v.ap1;
        1:       adDrv = v.ap2;
        2:       adDrv = v.rd ? 16'h0 : v.wdHi;
        3:       adDrv = v.rd ? 16'h0 : v.wdLo;
        default: adDrv = 16'h0;
      endcase
      ackDrv = (selCycle >= 0) && (v.ackDelay >= 0) && (t == selCycle + v.ackDelay);
      driveBus(t == 0, (t == 0) ? v.rd : 1'b0, adDrv, ackDrv, ackDrv ? v.rdata : 32'h0);
    end
    checkOutput({v.name, ".selCount"}, selCount, (v.expSelCycle >= 0) ? 1 : 0);
    checkOutput({v.name, ".selCycle"}, selCycle, v.expSelCycle);
    checkOutput({v.name, ".addr"}, {12'h0, addr}, {12'h0, v.expAddr});
    checkOutput({v.name, ".wdata"}, wdata, v.expWdata);
    checkOutput({v.name, ".rdWrN"}, {31'h0, rdwrn}, (v.expSelCycle >= 0) ? {31'h0, v.rd} : 32'h0);
    checkOutput({v.name, ".ackCount"}, ackCount, v.expAckCount);
    checkOutput({v.name, ".ackCycle"}, ackCycle, v.expAckCycle);
    checkOutput({v.name, ".ad0"}, {16'h0, ad0}, {16'h0, v.expAd0});
    checkOutput({v.name, ".ad1"}, {16'h0, ad1}, {16'h0, v.expAd1});
    checkOutput({v.name, ".hzLow"}, hzLow, v.expHzLow);
    checkOutput({v.name, ".adWhileHz"}, adBad, 0);
    checkOutput({v.name, ".toCount"}, toCount, (v.expToCycle >= 0) ? 1 : 0);
    checkOutput({v.name, ".toCycle"}, toCycle, v.expToCycle);
  endtask

  // Safety net so the run always ends even if something stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    int ackSeen;
    int selSeen;
    //            name                 rd    ap1       ap2       wdHi      wdLo      dly rdata          sel addr      wdata          ackC cnt ad0       ad1       hz  to
    vecs[0] = '{"wr_match",          1'b0, 16'h0000, 16'h0004, 16'h0101, 16'h0202, 3,  32'h0,         4, 20'h00004, 32'h01010202,  8,  1,  16'h0000, 16'h0000, 0, -1};
    vecs[1] = '{"rd_match",          1'b1, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 1,  32'hDEADBEEF,  2, 20'h00008, 32'h0,         4,  2,  16'hDEAD, 16'hBEEF, 2, -1};
    vecs[2] = '{"msn_mismatch",      1'b0, 16'h0050, 16'h0004, 16'h1111, 16'h2222, 1,  32'h0,        -1, 20'h00000, 32'h0,        -1,  0,  16'h0000, 16'h0000, 0, -1};
    vecs[3] = '{"rd_timeout",        1'b1, 16'h0000, 16'h0010, 16'h0000, 16'h0000, -1, 32'h0,         2, 20'h00010, 32'h0,        -1,  0,  16'h0000, 16'h0000, 0, 19};
    vecs[4] = '{"ack_with_sel",      1'b1, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 0,  32'hFFFFFFFF,  2, 20'h00020, 32'h0,        -1,  0,  16'h0000, 16'h0000, 0, 19};
    vecs[5] = '{"ap1_hi_ignored",    1'b0, 16'hA50F, 16'h1234, 16'hCAFE, 16'hF00D, 2,  32'h0,         4, 20'hF1234, 32'hCAFEF00D,  7,  1,  16'h0000, 16'h0000, 0, -1};
    vecs[6] = '{"rd_slow",           1'b1, 16'h0003, 16'hABCD, 16'h0000, 16'h0000, 5,  32'h12345678,  2, 20'h3ABCD, 32'h0,         8,  2,  16'h1234, 16'h5678, 2, -1};
    vecs[7] = '{"ack_last_cycle",    1'b1, 16'h0000, 16'h0030, 16'h0000, 16'h0000, 16, 32'h0F0FA5A5,  2, 20'h00030, 32'h0,        19,  2,  16'h0F0F, 16'hA5A5, 2, -1};
    vecs[8] = '{"ack_after_timeout", 1'b0, 16'h0000, 16'h0044, 16'h5A5A, 16'hA5A5, 17, 32'h0,         4, 20'h00044, 32'h5A5AA5A5, -1,  0,  16'h0000, 16'h0000, 0, 21};

    rstN = 1'b0;
    driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset.highZ", {31'h0, mibHighZ}, 32'h1);
    checkOutput("reset.ack", {31'h0, mibAck}, 32'h0);
    checkOutput("reset.ad", {16'h0, mibAdOut}, 32'h0);
    checkOutput("reset.sel", {31'h0, cmdSel}, 32'h0);
    checkOutput("reset.timeout", {31'h0, cmdTimeout}, 32'h0);
    checkOutput("reset.addr", {12'h0, cmdAddr}, 32'h0);
    checkOutput("reset.wdata", cmdWdata, 32'h0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Abort: a new read start arrives while the write waits for its local ack.
    $display("[TB] abort during CMD_WAIT");
    @(negedge clk); driveBus(1'b1, 1'b0, 16'h0000, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0040, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h1111, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h2222, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("abort.oldSel", {31'h0, cmdSel}, 32'h1);
    checkOutput("abort.oldAddr", {12'h0, cmdAddr}, 32'h00040);
    driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk); driveBus(1'b1, 1'b1, 16'h0000, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0080, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("abort.newSel", {31'h0, cmdSel}, 32'h1);
    checkOutput("abort.newAddr", {12'h0, cmdAddr}, 32'h00080);
    checkOutput("abort.newRdWrN", {31'h0, cmdRdWrN}, 32'h1);
    checkOutput("abort.noOldAck", {31'h0, mibAck}, 32'h0);
    driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0, 1'b1, 32'hCAFEBABE);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    checkOutput("abort.ackHi", {31'h0, mibAck}, 32'h1);
    checkOutput("abort.adHi", {16'h0, mibAdOut}, 32'h0000CAFE);
    checkOutput("abort.hzHi", {31'h0, mibHighZ}, 32'h0);
    @(negedge clk);
    checkOutput("abort.adLo", {16'h0, mibAdOut}, 32'h0000BABE);
    @(negedge clk);
    checkOutput("abort.ackEnd", {31'h0, mibAck}, 32'h0);
    checkOutput("abort.hzEnd", {31'h0, mibHighZ}, 32'h1);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of RD_HI, then a normal write.
    $display("[TB] reset during RD_HI");
    @(negedge clk); driveBus(1'b1, 1'b1, 16'h0000, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0050, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0, 1'b1, 32'h11223344);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    checkOutput("rstRd.ackHi", {31'h0, mibAck}, 32'h1);
    checkOutput("rstRd.adHi", {16'h0, mibAdOut}, 32'h00001122);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rstRd.asyncHz", {31'h0, mibHighZ}, 32'h1);
    checkOutput("rstRd.asyncAck", {31'h0, mibAck}, 32'h0);
    checkOutput("rstRd.asyncAd", {16'h0, mibAdOut}, 32'h0);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkOutput("rstRd.stillIdleAck", {31'h0, mibAck}, 32'h0);
    applyStimulus(vecs[0]);

    // A start while read data is on the bus is ignored and the read finishes.
    $display("[TB] start during RD_HI ignored");
    @(negedge clk); driveBus(1'b1, 1'b1, 16'h0000, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0060, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0, 1'b1, 32'h55667788);
    @(negedge clk);
    checkOutput("rdErr.adHi", {16'h0, mibAdOut}, 32'h00005566);
    driveBus(1'b1, 1'b0, 16'h0000, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rdErr.adLo", {16'h0, mibAdOut}, 32'h00007788);
    checkOutput("rdErr.ackLo", {31'h0, mibAck}, 32'h1);
    checkOutput("rdErr.hzLo", {31'h0, mibHighZ}, 32'h0);
    driveBus(1'b0, 1'b0, 16'h0064, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rdErr.hzEnd", {31'h0, mibHighZ}, 32'h1);
    driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    selSeen = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (cmdSel) selSeen++;
    end
    checkOutput("rdErr.noSel", selSeen, 0);

    // Back-to-back: read start on the first idle cycle after the write ack.
    $display("[TB] back-to-back write then read");
    @(negedge clk); driveBus(1'b1, 1'b0, 16'h0000, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h000C, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'hAAAA, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h5555, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("b2b.wrWdata", cmdWdata, 32'hAAAA5555);
    checkOutput("b2b.wrAddr", {12'h0, cmdAddr}, 32'h0000C);
    driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0, 1'b1, 32'h0);
    @(negedge clk);
    checkOutput("b2b.wrAck", {31'h0, mibAck}, 32'h1);
    driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("b2b.wrAckEnd", {31'h0, mibAck}, 32'h0);
    driveBus(1'b1, 1'b1, 16'h0000, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0010, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("b2b.rdSel", {31'h0, cmdSel}, 32'h1);
    checkOutput("b2b.rdAddr", {12'h0, cmdAddr}, 32'h00010);
    driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0, 1'b1, 32'h13579BDF);
    ackSeen = 0;
    @(negedge clk); driveBus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    if (mibAck) ackSeen++;
    checkOutput("b2b.rdHi", {16'h0, mibAdOut}, 32'h00001357);
    @(negedge clk);
    if (mibAck) ackSeen++;
    checkOutput("b2b.rdLo", {16'h0, mibAdOut}, 32'h00009BDF);
    @(negedge clk);
    if (mibAck) ackSeen++;
    checkOutput("b2b.rdAckCycles", ackSeen, 2);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
